snoop_cache_node: RTL
=====================

Name: snoop_cache_node

Overview:
- Parametrised MSI snooping-cache node: one private fully-associative L1 per processor, attached to a shared broadcast bus with a request/grant arbiter and to a write-back port towards memory.
- Successor of the single-message processor node:
  - configurable line count and tag/data widths
  - ready/valid local request port
  - explicit bus arbitration
  - buffered write-backs
  - memory fill handshake
  - race-safe upgrade of S lines
- Instantiated once per processor; the bus arbiter and memory model sit outside.

Parameters:
- N_LINES, 4, cache lines (power of 2, ≥2)
- TAG_W, 3, address tag width
- DATA_W, 3, line data width
- ID_W, 2, processor id width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- proc_id  in  ID_W  this node's id; static after reset
- req_valid / req_ready  in / out  1 / 1  local request handshake
- req_write  in  1  0 = read, 1 = write
- req_tag  in  TAG_W  request address tag
- req_data  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  DATA_W  read data; for writes, the written data
- bus_req / bus_gnt  out / in  1 / 1  bus arbitration
- bus_msg_out  out  2  00 INVALIDATE, 01 READ_MISS, 10 WRITE_MISS, 11 NONE
- bus_tag_out  out  TAG_W  tag of broadcast
- bus_msg_in  in  2  snooped message (11 = idle)
- bus_tag_in  in  TAG_W  snooped tag
- bus_src_in  in  ID_W  originator of the snooped message
- abort_mem  out  1  pulse: this node supplies the data, memory must not respond
- snoop_busy  out  1  snoop write-back buffer occupied; arbiter must not grant while high
- wb_valid / wb_ready  out / in  1 / 1  write-back handshake
- wb_tag, wb_data  out  TAG_W, DATA_W  write-back payload
- fill_valid  in  1  memory read data valid
- fill_data  in  DATA_W  memory read data

Behaviour:
- Reset: every line Estado = I, Tag = 0, Dado = 0; victim pointer = 0; FSM in IDLE. Outputs: req_ready = 1; every other output = 0, except bus_msg_out = NONE.
- Hit definition: tag match AND state ≠ I. Lowest-index match wins.
- FSM states: IDLE, LOOKUP, WB, ARB, FILL, RESP.
- IDLE:
  - req_ready = 1.
  - Accepting a request (req_valid & req_ready) latches write/tag/data and moves to LOOKUP. req_ready = 0 in every other state.
- LOOKUP (one cycle):
  - Read hit (S or M) → RESP with the line's data.
  - Write hit, line in M → write data into the line → RESP.
  - Write hit, line in S → ARB; the message to send is INVALIDATE.
  - Miss, victim selection: lowest-index I line; otherwise the line at the round-robin pointer, then pointer increments modulo N_LINES.
  - Victim in M → copy tag/data into the local WB buffer, set the victim to I in this cycle, go to WB.
  - Victim not in M → ARB.
- WB: wb_valid held with stable payload until wb_ready; then → ARB.
- ARB:
  - bus_req = 1 until bus_gnt.
  - In the grant cycle: bus_msg_out / bus_tag_out are driven for exactly one cycle and bus_req drops.
  - Upgrade race: if the target S line was invalidated by a snoop while in ARB, send WRITE_MISS instead of INVALIDATE and allocate as a miss. Victim handling is redone; a write-back is never needed because the line is now I.
  - After an INVALIDATE: line → M, data written → RESP.
  - After a write miss: tag and data written, state M → RESP.
  - After a read miss → FILL.
- FILL: wait for fill_valid; line ← (tag, fill_data, S) → RESP.
- RESP: rsp_valid = 1 for one cycle → IDLE. Earliest back-to-back accept is 3 cycles after the previous accept.
- Snooping:
  - Runs every cycle in parallel with the FSM.
  - Ignored when bus_msg_in = NONE or bus_src_in = proc_id.
  - Message on a snoop hit: READ_MISS turns M → S; WRITE_MISS turns M → I and S → I; INVALIDATE turns S → I, and M → I defensively.
  - Any snoop hit on M: abort_mem pulses the same cycle; the line is copied into the snoop WB buffer and snoop_busy = 1.
- Write-back arbitration: the snoop WB buffer has priority over the local WB buffer. A local WB already handshaking is not interrupted; the snoop entry goes next. snoop_busy clears on the snoop entry's wb handshake.
- Simultaneous snoop and local update on the same line in the same cycle: the snoop is applied first and the local FSM sees the post-snoop state on its next evaluation. The local write never overrides an invalidation it has not yet been granted for.
- Reset mid-operation: immediate return to reset values. Pending WB is lost; the bench treats memory as indeterminate for that line.

Decomposition:
- Package snoop_pkg:
  - msi_state_t {I = 00, M = 01, S = 10}
  - bus_msg_t {INVALIDATE, READ_MISS, WRITE_MISS, NONE}
  - fsm_state_t
- Sub-module msi_next_state: a purely combinational transition function. Inputs: local op or snooped msg, current state. Outputs: next state, message, writeback flag. Shared with the existing node's protocol table.

Test Plan:
- Read miss, empty cache, tag 3. Expect:
  - bus READ_MISS with tag 3
  - fill_data 5 → line S
  - rsp_data 5
  - repeat read of tag 3 → hit, rsp in 2 cycles after accept, no bus_req
- Write tag 2, data 6, into a line in S. Expect:
  - INVALIDATE with tag 2, line → M, rsp_data 6
  - a peer node holding tag 2 in S goes to I
- N_LINES = 4, all lines M, read miss on tag 7. Expect:
  - victim = pointer line 0
  - wb_tag / wb_data = old contents, held across 3 cycles of wb_ready = 0
  - then READ_MISS
- Snooped READ_MISS from id 1 for tag 4, held here in M with data 2. Expect:
  - abort_mem pulse, line → S, snoop_busy = 1
  - wb carries tag 4, data 2; snoop_busy then clears
- Upgrade race: local write to S tag 1 waiting in ARB; peer WRITE_MISS for tag 1 snooped. Expect:
  - the grant sends WRITE_MISS, not INVALIDATE
  - line ends M with the new data
- Assert reset during FILL. Expect:
  - all lines I, req_ready = 1, bus_req = 0, wb_valid = 0 in the same cycle

Source files
------------

// File: rtl/snoop_cache_node_pkg.sv
// Shared types for the MSI snooping cache node: line states, bus messages, controller states.
package snoop_pkg;
  typedef enum logic [1:0] {I = 2'b00, M = 2'b01, S = 2'b10} msi_state_t;
  typedef enum logic [1:0] {INVALIDATE = 2'b00, READ_MISS = 2'b01, WRITE_MISS = 2'b10, NONE = 2'b11} bus_msg_t;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, ARB, FILL, RESP} fsm_state_t;
endpackage

// File: rtl/snoop_cache_node_if.sv
// Bundle of the local request, broadcast bus, write-back and fill channels of one cache node.
interface snoop_cache_node_if import snoop_pkg::*; #(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 3,
  parameter int ID_W   = 2
);
  logic              req_valid, req_ready, req_write;
  logic [TAG_W-1:0]  req_tag;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              bus_req, bus_gnt;
  bus_msg_t          bus_msg_out, bus_msg_in;
  logic [TAG_W-1:0]  bus_tag_out, bus_tag_in;
  logic [ID_W-1:0]   bus_src_in;
  logic              abort_mem, snoop_busy;
  logic              wb_valid, wb_ready;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_data;
  logic              fill_valid;
  logic [DATA_W-1:0] fill_data;

  modport slave (
    input  req_valid, req_write, req_tag, req_data, bus_gnt, bus_msg_in, bus_tag_in,
           bus_src_in, wb_ready, fill_valid, fill_data,
    output req_ready, rsp_valid, rsp_data, bus_req, bus_msg_out, bus_tag_out,
           abort_mem, snoop_busy, wb_valid, wb_tag, wb_data
  );
  modport master (
    output req_valid, req_write, req_tag, req_data, bus_gnt, bus_msg_in, bus_tag_in,
           bus_src_in, wb_ready, fill_valid, fill_data,
    input  req_ready, rsp_valid, rsp_data, bus_req, bus_msg_out, bus_tag_out,
           abort_mem, snoop_busy, wb_valid, wb_tag, wb_data
  );
endinterface

// File: rtl/snoop_cache_node_msi_next_state.sv
// MSI transition table: local read/write (message to broadcast) or snooped message (write-back flag).
module msi_next_state import snoop_pkg::*; (
  input  logic       snoop,
  input  logic       write,
  input  bus_msg_t   msg_in,
  input  msi_state_t cur,
  output msi_state_t nxt,
  output bus_msg_t   msg_out,
  output logic       wb
);
  always_comb begin
    nxt     = cur;
    msg_out = NONE;
    wb      = 1'b0;
    if (snoop) begin
      if (cur != I) begin
        case (msg_in)
          READ_MISS:              if (cur == M) nxt = S;
          WRITE_MISS, INVALIDATE: nxt = I;
          default: ;
        endcase
      end
      wb = (cur == M) && (msg_in != NONE);
    end else begin
      case (cur)
        I: begin
          nxt     = write ? M : S;
          msg_out = write ? WRITE_MISS : READ_MISS;
        end
        S: if (write) begin
          nxt     = M;
          msg_out = INVALIDATE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/snoop_cache_node.sv
// Fully-associative MSI L1 node: local request controller plus a snooper that runs every cycle.
module snoop_cache_node import snoop_pkg::*; #(
  parameter int N_LINES = 4,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 3,
  parameter int ID_W    = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [ID_W-1:0] proc_id,
  snoop_cache_node_if.slave io
);
  localparam int IDX_W = $clog2(N_LINES);
  typedef logic [IDX_W-1:0] idx_t;

  msi_state_t        st  [N_LINES];
  logic [TAG_W-1:0]  tag [N_LINES];
  logic [DATA_W-1:0] dat [N_LINES];
  fsm_state_t        state, state_nxt;
  idx_t              ptr, tgt;
  logic              op_write;
  logic [TAG_W-1:0]  op_tag, lwb_tag, snp_tag;
  logic [DATA_W-1:0] op_data, resp_data, lwb_data, snp_data;
  bus_msg_t          pend_msg;
  logic              snp_busy, wb_lock, lock_snp;

  logic       hit, free_any, snp_hit;
  idx_t       hit_idx, free_idx, snp_idx;
  always_comb begin
    hit = 1'b0; hit_idx = '0; free_any = 1'b0; free_idx = '0; snp_hit = 1'b0; snp_idx = '0;
    for (int i = N_LINES - 1; i >= 0; i--) begin
      if (st[i] != I && tag[i] == op_tag) begin hit = 1'b1; hit_idx = i[IDX_W-1:0]; end
      if (st[i] == I) begin free_any = 1'b1; free_idx = i[IDX_W-1:0]; end
      if (st[i] != I && tag[i] == io.bus_tag_in) begin snp_hit = 1'b1; snp_idx = i[IDX_W-1:0]; end
    end
  end

  logic       snp_apply, snp_wb, loc_wb_unused;
  msi_state_t snp_nxt, loc_nxt_unused, loc_cur;
  bus_msg_t   loc_msg, snp_msg_unused;
  assign snp_apply = (io.bus_msg_in != NONE) && (io.bus_src_in != proc_id) && snp_hit;
  assign loc_cur   = hit ? st[hit_idx] : I;

  msi_next_state u_snp (.snoop(1'b1), .write(1'b0), .msg_in(io.bus_msg_in), .cur(st[snp_idx]),
                        .nxt(snp_nxt), .msg_out(snp_msg_unused), .wb(snp_wb));
  msi_next_state u_loc (.snoop(1'b0), .write(op_write), .msg_in(NONE), .cur(loc_cur),
                        .nxt(loc_nxt_unused), .msg_out(loc_msg), .wb(loc_wb_unused));

  idx_t       vic_idx, lk_idx, alloc_idx, wr_idx;
  logic       vic_m, lk_stall, race;
  msi_state_t tgt_eff;
  bus_msg_t   send_msg;
  assign vic_idx   = free_any ? free_idx : ptr;
  assign vic_m     = (st[vic_idx] == M);
  assign lk_idx    = hit ? hit_idx : vic_idx;
  // A snoop touching the line under lookup wins; lookup re-evaluates next cycle on the new state.
  assign lk_stall  = snp_apply && (snp_idx == lk_idx);
  assign tgt_eff   = (snp_apply && snp_idx == tgt) ? snp_nxt : st[tgt];
  assign race      = (pend_msg == INVALIDATE) && (tgt_eff == I);
  assign send_msg  = race ? WRITE_MISS : pend_msg;
  assign alloc_idx = (free_any && free_idx < tgt) ? free_idx : tgt;
  assign wr_idx    = race ? alloc_idx : tgt;

  // Snoop entry has priority, but a transfer already presented is held until it completes.
  logic sel_snp, wb_fire;
  assign sel_snp       = wb_lock ? lock_snp : snp_busy;
  assign io.wb_valid   = sel_snp ? snp_busy : (state == WB);
  assign io.wb_tag     = sel_snp ? snp_tag  : lwb_tag;
  assign io.wb_data    = sel_snp ? snp_data : lwb_data;
  assign io.snoop_busy = snp_busy;
  assign io.abort_mem  = snp_apply && snp_wb;
  assign wb_fire       = io.wb_valid && io.wb_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (io.req_valid) state_nxt = LOOKUP;
      LOOKUP: if (!lk_stall) begin
        if (loc_msg == NONE)                   state_nxt = RESP;
        else if (loc_msg != INVALIDATE && vic_m) state_nxt = WB;
        else                                   state_nxt = ARB;
      end
      WB:     if (wb_fire && !sel_snp) state_nxt = ARB;
      ARB:    if (io.bus_gnt) state_nxt = (send_msg == READ_MISS) ? FILL : RESP;
      FILL:   if (io.fill_valid) state_nxt = RESP;
      RESP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    io.req_ready   = (state == IDLE);
    io.bus_req     = (state == ARB);
    io.rsp_valid   = (state == RESP);
    io.rsp_data    = resp_data;
    io.bus_msg_out = NONE;
    io.bus_tag_out = '0;
    if (state == ARB && io.bus_gnt) begin
      io.bus_msg_out = send_msg;
      io.bus_tag_out = op_tag;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_LINES; i++) begin
        st[i] <= I; tag[i] <= '0; dat[i] <= '0;
      end
      ptr <= '0; tgt <= '0; op_write <= 1'b0; op_tag <= '0; op_data <= '0;
      pend_msg <= NONE; resp_data <= '0; lwb_tag <= '0; lwb_data <= '0;
      snp_busy <= 1'b0; snp_tag <= '0; snp_data <= '0; wb_lock <= 1'b0; lock_snp <= 1'b0;
    end else begin
      if (snp_apply) begin
        st[snp_idx] <= snp_nxt;
        if (snp_wb && !snp_busy) begin
          snp_busy <= 1'b1; snp_tag <= tag[snp_idx]; snp_data <= dat[snp_idx];
        end
      end
      if (wb_fire && sel_snp) snp_busy <= 1'b0;
      if (wb_fire)            wb_lock <= 1'b0;
      else if (io.wb_valid) begin wb_lock <= 1'b1; lock_snp <= sel_snp; end

      // Local updates follow the snoop update so they take effect on top of it.
      case (state)
        IDLE: if (io.req_valid) begin
          op_write <= io.req_write; op_tag <= io.req_tag; op_data <= io.req_data;
        end
        LOOKUP: if (!lk_stall) begin
          tgt <= lk_idx; pend_msg <= loc_msg;
          if (loc_msg == NONE) begin
            resp_data <= op_write ? op_data : dat[hit_idx];
            if (op_write) dat[hit_idx] <= op_data;
          end else if (loc_msg != INVALIDATE) begin
            if (!free_any) ptr <= ptr + 1'b1;
            if (vic_m) begin
              lwb_tag <= tag[vic_idx]; lwb_data <= dat[vic_idx]; st[vic_idx] <= I;
            end
          end
        end
        ARB: if (io.bus_gnt && send_msg != READ_MISS) begin
          st[wr_idx] <= M; tag[wr_idx] <= op_tag; dat[wr_idx] <= op_data; resp_data <= op_data;
        end
        FILL: if (io.fill_valid) begin
          st[tgt] <= S; tag[tgt] <= op_tag; dat[tgt] <= io.fill_data; resp_data <= io.fill_data;
        end
        default: ;
      endcase
    end
  end
endmodule
